// File: rtl/spi_dev_core_nx.sv
// SPI device core: synchronizes async SPI pins into clk_slow, shifts words in/out,
// and reports word strobes, TX acks, CS edges, per-frame word count and partial-frame errors.
module spi_dev_core_nx #(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CPOL      = 0,
   parameter int unsigned CPHA      = 0,
   parameter int unsigned LSB_FIRST = 0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              clk_slow,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [WORD_W-1:0] user_out,
   output logic              user_out_stb,
   input  logic [WORD_W-1:0] user_in,
   output logic              user_in_ack,
   output logic              csn_state,
   output logic              csn_rise,
   output logic              csn_fall,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              frame_err
);

   localparam logic             IDLE_CLK    = (CPOL != 0);
   localparam logic             SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
   localparam int unsigned      BW          = $clog2(WORD_W);
   localparam logic [BW-1:0]    LAST_BIT    = BW'(WORD_W - 1);

   logic r_clk_s1, r_clk_s2, r_clk_d;
   logic r_cs_s1, r_cs_s2, r_cs_d;
   logic r_mosi_s1, r_mosi_s2;

   logic [BW-1:0]     r_bit_cnt;
   logic [WORD_W-1:0] r_rx;
   logic [WORD_W-1:0] r_tx_sh;
   logic [WORD_W-1:0] r_tx_buf;
   logic              r_first;
   logic              r_done;

   logic              w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;
   logic              w_active, w_sample, w_shift, w_last;
   logic [WORD_W-1:0] w_rx_next;
   logic [WORD_W-1:0] w_tx_shifted;
   logic              w_tx_bit;

   always_comb begin
      w_clk_rise = r_clk_s2 & ~r_clk_d;
      w_clk_fall = ~r_clk_s2 & r_clk_d;
      w_cs_fall  = ~r_cs_s2 & r_cs_d;
      w_cs_rise  = r_cs_s2 & ~r_cs_d;
      w_active   = ~r_cs_d;
      w_sample   = w_active & (SAMPLE_RISE ? w_clk_rise : w_clk_fall);
      w_shift    = w_active & (SAMPLE_RISE ? w_clk_fall : w_clk_rise);
      w_last     = w_sample & (r_bit_cnt == LAST_BIT);
      if (LSB_FIRST != 0) begin
         w_rx_next    = {r_mosi_s2, r_rx[WORD_W-1:1]};
         w_tx_shifted = r_tx_sh >> 1;
         w_tx_bit     = r_tx_sh[0];
      end else begin
         w_rx_next    = {r_rx[WORD_W-2:0], r_mosi_s2};
         w_tx_shifted = r_tx_sh << 1;
         w_tx_bit     = r_tx_sh[WORD_W-1];
      end
   end

   assign csn_state   = r_cs_d;
   assign spi_miso_oe = ~r_cs_d;
   assign spi_miso    = r_cs_d ? 1'b0 : w_tx_bit;

   always_ff @(posedge clk_slow) begin
      if (!rst) begin
         r_clk_s1     <= IDLE_CLK;
         r_clk_s2     <= IDLE_CLK;
         r_clk_d      <= IDLE_CLK;
         r_cs_s1      <= 1'b1;
         r_cs_s2      <= 1'b1;
         r_cs_d       <= 1'b1;
         r_mosi_s1    <= 1'b0;
         r_mosi_s2    <= 1'b0;
         r_bit_cnt    <= '0;
         r_rx         <= '0;
         r_tx_sh      <= '0;
         r_tx_buf     <= '0;
         r_first      <= 1'b0;
         r_done       <= 1'b0;
         user_out     <= '0;
         user_out_stb <= 1'b0;
         user_in_ack  <= 1'b0;
         csn_rise     <= 1'b0;
         csn_fall     <= 1'b0;
         word_cnt     <= '0;
         frame_err    <= 1'b0;
      end else begin
         r_clk_s1  <= spi_clk;
         r_clk_s2  <= r_clk_s1;
         r_clk_d   <= r_clk_s2;
         r_cs_s1   <= spi_cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_d    <= r_cs_s2;
         r_mosi_s1 <= spi_mosi;
         r_mosi_s2 <= r_mosi_s1;

         csn_fall     <= w_cs_fall;
         csn_rise     <= w_cs_rise;
         user_in_ack  <= w_cs_fall | w_last;
         r_done       <= w_last;
         user_out_stb <= r_done;
         frame_err    <= w_cs_rise & (r_bit_cnt != '0);

         if (w_cs_fall) begin
            r_bit_cnt <= '0;
            word_cnt  <= '0;
            r_rx      <= '0;
            r_first   <= 1'b1;
         end else if (w_cs_rise) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
         end else if (w_sample) begin
            r_rx <= w_rx_next;
            if (w_last) begin
               r_bit_cnt <= '0;
               user_out  <= w_rx_next;
               if (word_cnt != '1)
                  word_cnt <= word_cnt + CNT_W'(1);
            end else begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
            end
         end

         // The word acked at CS fall goes straight to the shifter so CPHA=0 can
         // present its first bit before any clock; later words wait in r_tx_buf
         // until the first shift edge of their slot (bit counter back at 0).
         if (user_in_ack) begin
            r_tx_buf <= user_in;
            if (r_first) begin
               r_tx_sh <= user_in;
               r_first <= 1'b0;
            end
         end else if (w_shift) begin
            r_tx_sh <= (r_bit_cnt == '0) ? r_tx_buf : w_tx_shifted;
         end
      end
   end

endmodule

// File: doc/spi_dev_core_nx.md
SPI_DEV_CORE_NX -- requirements
Module: spi_dev_core_nx

Interface
REQ-001 SHALL have parameter WORD_W, default 8, SPI word width in bits (4..32).
REQ-002 SHALL have parameter CPOL, default 0, idle level of spi_clk.
REQ-003 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter LSB_FIRST, default 0, 1 = bit 0 transferred first on both MOSI and MISO.
REQ-005 SHALL have parameter CNT_W, default 8, width of word_cnt.
REQ-006 SHALL have port clk_slow, input, 1, system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have ports spi_clk, spi_mosi, spi_cs_n, input, 1 each, asynchronous SPI pins.
REQ-009 SHALL have port spi_miso, output, 1, device data out.
REQ-010 SHALL have port spi_miso_oe, output, 1, MISO drive enable.
REQ-011 SHALL have ports user_out, output, WORD_W, and user_out_stb, output, 1: received word and its 1-cycle valid strobe.
REQ-012 SHALL have ports user_in, input, WORD_W, and user_in_ack, output, 1: next TX word, sampled in the cycle user_in_ack is high.
REQ-013 SHALL have ports csn_state, csn_rise, csn_fall, output, 1 each: synchronized CS level and 1-cycle edge pulses.
REQ-014 SHALL have port word_cnt, output, CNT_W, count of complete words received in current frame.
REQ-015 SHALL have port frame_err, output, 1, 1-cycle pulse on a frame ending mid-word.

Function
REQ-016 SHALL pass spi_clk, spi_mosi, spi_cs_n each through a 2-flop synchronizer, then detect edges with one further register.
REQ-017 SHALL support spi_clk high and low times of at least 2 clk_slow cycles each, and at least 4 clk_slow cycles from CS fall to the first spi_clk edge.
REQ-018 SHALL define the sample edge as rising when CPOL xor CPHA = 0, falling otherwise; the shift edge is the opposite edge.
REQ-019 SHALL ignore spi_clk edges while csn_state = 1.
REQ-020 SHALL pulse csn_fall / csn_rise in the cycle csn_state changes; latency from pin to pulse is 3 clk_slow cycles.
REQ-021 SHALL, on csn_fall, clear the bit counter and word_cnt, pulse user_in_ack, and load user_in into the TX shift register.
REQ-022 SHALL shift one MOSI bit into the RX register per sample edge, in MSB-first or LSB-first order per LSB_FIRST.
REQ-023 SHALL, on the WORD_W-th sample edge, update user_out and pulse user_out_stb 1 cycle later, wrap the bit counter to 0, and increment word_cnt, saturating at 2^CNT_W-1.
REQ-024 SHALL, in the same cycle as the WORD_W-th sample edge, pulse user_in_ack and load user_in as the next TX word.
REQ-025 SHALL, with CPHA=0, present TX bit 0 of the first word on spi_miso within 3 cycles of csn_fall, then advance one bit per shift edge; the shift edge after the last sample presents bit 0 of the next word.
REQ-026 SHALL, with CPHA=1, advance spi_miso one bit on each shift (leading) edge, the first shift edge of each word presenting that word's bit 0.
REQ-027 SHALL drive spi_miso_oe = !csn_state, and drive spi_miso = 0 while csn_state = 1.
REQ-028 SHALL, on csn_rise with bit counter != 0, discard the partial word, pulse frame_err, and not pulse user_out_stb.
REQ-029 SHALL never assert user_out_stb and frame_err in the same cycle.

Reset
REQ-030 SHALL, while rst = 0, force: synchronizers to idle (cs = 1, clk = CPOL), csn_state = 1, and all other outputs, counters and shift registers = 0.
REQ-031 SHALL abort any frame in progress at reset without a strobe, ack or frame_err; if spi_cs_n is low at release, a csn_fall follows after 3 cycles and a new frame starts.

Verification
REQ-032 SHALL cover: mode 0, WORD_W=8, MOSI 0xA5,0x3C; user_in starts at 0x5A and is incremented on each ack -> user_out 0xA5,0x3C; MISO shows 0x5A,0x5B; word_cnt=2; 3 acks.
REQ-033 SHALL cover: CPOL=1, CPHA=1, MOSI 0xC3 -> user_out 0xC3; MISO bits match user_in MSB-first.
REQ-034 SHALL cover: WORD_W=16, LSB_FIRST=1, MOSI bits LSB-first of 0x1234 -> user_out 0x1234, one strobe.
REQ-035 SHALL cover: frame of 13 bits (WORD_W=8) -> one strobe, then frame_err at csn_rise, word_cnt=1.
REQ-036 SHALL cover: CNT_W=2, 5-word frame -> word_cnt saturates at 3.
REQ-037 SHALL cover: rst low after bit 4 of a word, released with CS still low -> no strobe, csn_fall 3 cycles after release, next 8 bits form a full word.
